width_chunk_serializer: RTL and testbench
=========================================

Name: width_chunk_serializer

Overview:
- Upstream feeder for the lane-split consumer.
- Accepts one WIDTH-bit word over a valid/ready handshake and emits it as NUM_OUT sequential chunks of CHUNK_W bits each, with CHUNK_W <= MAX_WIDTH.
- NUM_OUT uses the team's doubling rule: start at 1 and double while ceil(WIDTH/NUM_OUT) > MAX_WIDTH. The consumer's lane count and this block's beat count therefore always agree (WIDTH=33, MAX_WIDTH=11 gives 4 beats of 9 bits).

Parameters:
- WIDTH, 33: input word width in bits, >= 1.
- MAX_WIDTH, 11: maximum chunk width in bits, >= 1.
- NUM_OUT, derived (localparam): beat count per word, always a power of two.
- CHUNK_W, derived (localparam): ceil(WIDTH/NUM_OUT).
- IDX_W, derived (localparam): max(1, $clog2(NUM_OUT)).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset: synchronous, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  WIDTH  input word.
- out_valid  out  1  chunk valid.
- out_ready  in  1  downstream accepts the chunk.
- out_data  out  CHUNK_W  current chunk.
- out_idx  out  IDX_W  chunk index, 0..NUM_OUT-1.
- out_last  out  1  high on the final chunk of a word.

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, out_valid=0, in_ready=1, out_idx=0, out_last=0, out_data=0, holding register cleared.
- FSM IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, capture in_data into holding register, set beat counter to 0, go to SEND.
- FSM SEND: out_valid=1, out_data=chunk[cnt], out_idx=cnt, out_last=(cnt==NUM_OUT-1).
  - out_ready=1 and not last beat: cnt+1.
  - out_ready=1 on last beat: if in_valid=1, capture the new word, reset cnt=0 and stay in SEND (no bubble). Otherwise go to IDLE.
- in_ready in SEND = out_ready && out_last (combinational). This is the only in_data capture point outside IDLE.
- Latency: word accepted in cycle N gives chunk 0 valid in cycle N+1. Sustained throughput is one word per NUM_OUT cycles.
- Chunk k = hold[k*CHUNK_W +: CHUNK_W], LSB-first by default. Bits at or above WIDTH read as 0, so the final chunk is zero-padded (33 bits -> pad 3).
- Backpressure: while out_valid && !out_ready, out_data/out_idx/out_last hold stable. Holding register never changes mid-word.
- NUM_OUT==1 (WIDTH <= MAX_WIDTH): every beat has out_last=1 and out_idx=0. Pass-through with one register stage.
- Reset mid-word: the word in flight is discarded. The next cycle is IDLE with out_valid=0.
- in_valid asserted while in_ready=0 is ignored. Upstream must hold it.
- All outputs are registered except in_ready.

Optional Feature:
- Macro: WIDTH_CHUNK_SER_MSB_FIRST_EN.
- Defined: chunks are emitted most-significant first. Beat k carries chunk index NUM_OUT-1-k. out_idx still counts 0..NUM_OUT-1 in emission order. The zero-padded chunk is emitted first.
- Undefined: LSB-first ordering as above.

Decomposition:
- Package width_chunk_pkg:
  - function num_out(width, max_width), the doubling loop;
  - function chunk_w(width, max_width);
  - enum state_e {IDLE, SEND}.
- The consumer stage imports the same package so both sides derive identical NUM_OUT.
- No sub-module. Chunk select is an indexed part-select of a zero-extended register of NUM_OUT*CHUNK_W bits.

Test Plan:
- Default params, in_data=33'h1_2345_6789, out_ready=1 -> beats 0x189, 0x0B3, 0x0D1, 0x024 with out_idx 0..3. out_last on beat 3 only. Chunk 0 appears 1 cycle after acceptance.
- Two back-to-back words with in_valid held high and out_ready=1 -> 8 consecutive out_valid cycles with no gap. in_ready pulses only on the out_last cycles.
- Random out_ready stalls (e.g. low 3 cycles on beat 2) -> out_data/out_idx stable throughout the stall. Sequence unchanged. in_ready stays 0.
- WIDTH=8, MAX_WIDTH=11 -> NUM_OUT=1, CHUNK_W=8. in_data=8'hA5 -> single beat 0xA5 with out_last=1, out_idx=0.
- rst asserted during beat 1 of a word -> next cycle out_valid=0, in_ready=1. A subsequent word 33'h0_0000_01FF yields 0x1FF, 0, 0, 0.
- With WIDTH_CHUNK_SER_MSB_FIRST_EN defined, in_data=33'h1_2345_6789 -> beats 0x024, 0x0D1, 0x0B3, 0x189. out_last on beat 0x189.

Source files
------------

// File: rtl/width_chunk_serializer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | width_chunk_pkg: beat-count rule and FSM states shared by both     |
// | sides of the lane split.                            Revision: 1.0 |
// +--------------------------------------------------------------------+
package width_chunk_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   // Double the beat count until every chunk fits within max_width bits.
   function automatic int num_out(input int width, input int max_width);
      int n;
      n = 1;
      while (((width + n - 1) / n) > max_width) n = n * 2;
      return n;
   endfunction

   function automatic int chunk_w(input int width, input int max_width);
      int n;
      n = num_out(width, max_width);
      return (width + n - 1) / n;
   endfunction

   function automatic int idx_w(input int width, input int max_width);
      int n;
      n = num_out(width, max_width);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/width_chunk_serializer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | width_chunk_serializer_if: word-in / chunk-out handshake bundle.   |
// |                                                    Revision: 1.0 |
// +--------------------------------------------------------------------+
interface width_chunk_serializer_if #(
   parameter int WIDTH     = 33,
   parameter int MAX_WIDTH = 11
);
   import width_chunk_pkg::*;

   localparam int CHUNK_W = chunk_w(WIDTH, MAX_WIDTH);
   localparam int IDX_W   = idx_w(WIDTH, MAX_WIDTH);

   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_data;
   logic               out_valid;
   logic               out_ready;
   logic [CHUNK_W-1:0] out_data;
   logic [IDX_W-1:0]   out_idx;
   logic               out_last;

   // Serializer side.
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_idx, out_last
   );

   // Environment side: word producer and chunk consumer.
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_idx, out_last
   );

endinterface
`default_nettype wire

// File: rtl/width_chunk_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | width_chunk_serializer: splits one WIDTH-bit word into NUM_OUT     |
// | registered chunks; WIDTH_CHUNK_SER_MSB_FIRST_EN reverses order.    |
// |                                                    Revision: 1.0 |
// +--------------------------------------------------------------------+
module width_chunk_serializer
   import width_chunk_pkg::*;
#(
   parameter int WIDTH     = 33,
   parameter int MAX_WIDTH = 11
) (
   input  wire logic              clk,
   input  wire logic              rst,
   width_chunk_serializer_if.slave bus
);

   localparam int NUM_OUT = num_out(WIDTH, MAX_WIDTH);
   localparam int CHUNK_W = chunk_w(WIDTH, MAX_WIDTH);
   localparam int IDX_W   = idx_w(WIDTH, MAX_WIDTH);
   localparam int HOLD_W  = NUM_OUT * CHUNK_W;
   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_OUT - 1);

   state_e             r_state, w_state_n;
   logic [IDX_W-1:0]   r_cnt, w_cnt_n, w_sel;
   logic [HOLD_W-1:0]  r_hold, w_hold_n;
   logic [CHUNK_W-1:0] w_chunk;
   logic               w_in_ready;

   logic               r_out_valid;
   logic [CHUNK_W-1:0] r_out_data;
   logic [IDX_W-1:0]   r_out_idx;
   logic               r_out_last;

   // r_out_last is only ever set in SEND, so this is the last-beat handoff.
   assign w_in_ready = (r_state == IDLE) || (bus.out_ready && r_out_last);

   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_hold_n  = r_hold;
      case (r_state)
         IDLE: begin
            if (bus.in_valid && w_in_ready) begin
               w_hold_n  = HOLD_W'(bus.in_data);
               w_cnt_n   = '0;
               w_state_n = SEND;
            end
         end
         SEND: begin
            if (bus.out_ready) begin
               if (r_cnt != c_last_idx) begin
                  w_cnt_n = r_cnt + IDX_W'(1);
               end else if (bus.in_valid) begin
                  w_hold_n = HOLD_W'(bus.in_data);
                  w_cnt_n  = '0;
               end else begin
                  w_cnt_n   = '0;
                  w_state_n = IDLE;
               end
            end
         end
         default: begin
            w_cnt_n   = '0;
            w_state_n = IDLE;
         end
      endcase
   end

`ifdef WIDTH_CHUNK_SER_MSB_FIRST_EN
   assign w_sel = c_last_idx - w_cnt_n;
`else
   assign w_sel = w_cnt_n;
`endif

   // Upper pad bits of the holding register are zero, padding the top chunk.
   assign w_chunk = CHUNK_W'(w_hold_n >> (32'(w_sel) * CHUNK_W));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_hold      <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_idx   <= '0;
         r_out_last  <= 1'b0;
      end else begin
         r_state     <= w_state_n;
         r_cnt       <= w_cnt_n;
         r_hold      <= w_hold_n;
         r_out_valid <= (w_state_n == SEND);
         r_out_data  <= (w_state_n == SEND) ? w_chunk : '0;
         r_out_idx   <= w_cnt_n;
         r_out_last  <= (w_state_n == SEND) && (w_cnt_n == c_last_idx);
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_idx   = r_out_idx;
   assign bus.out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_width_chunk_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_width_chunk_serializer: directed vectors for the 33/11 and 8/11 |
// | configurations.                                    Revision: 1.0 |
// +--------------------------------------------------------------------+
module tb_width_chunk_serializer;

   logic clk;
   logic rst;

   width_chunk_serializer_if #(.WIDTH(33), .MAX_WIDTH(11)) bus ();
   width_chunk_serializer_if #(.WIDTH(8),  .MAX_WIDTH(11)) bus8 ();

   width_chunk_serializer #(.WIDTH(33), .MAX_WIDTH(11)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   width_chunk_serializer #(.WIDTH(8), .MAX_WIDTH(11)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // LSB-first chunk values of each test word (9-bit chunks).
   logic [31:0] x1c [4] = '{32'h189, 32'h0B3, 32'h0D1, 32'h024};
   logic [31:0] w2c [4] = '{32'h0EF, 32'h0DF, 32'h1AB, 32'h01B};
   logic [31:0] f1c [4] = '{32'h1FF, 32'h000, 32'h000, 32'h000};

   // Chunk index carried by emission beat k.
   function automatic int ord(input int k);
`ifdef WIDTH_CHUNK_SER_MSB_FIRST_EN
      return 3 - k;
`else
      return k;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_beat(input string tag, input logic [31:0] data, input int k);
      check({tag, " valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, " data"},  32'(bus.out_data),  data);
      check({tag, " idx"},   32'(bus.out_idx),   32'(k));
      check({tag, " last"},  32'(bus.out_last),  (k == 3) ? 32'd1 : 32'd0);
   endtask

   initial begin
      rst            = 1'b1;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.out_ready  = 1'b1;
      bus8.in_valid  = 1'b0;
      bus8.in_data   = '0;
      bus8.out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;

      // Reset state
      check("rst out_valid", 32'(bus.out_valid), 32'd0);
      check("rst in_ready",  32'(bus.in_ready),  32'd1);
      check("rst out_idx",   32'(bus.out_idx),   32'd0);
      check("rst out_last",  32'(bus.out_last),  32'd0);
      check("rst out_data",  32'(bus.out_data),  32'd0);

      // Single word, chunk 0 one cycle after acceptance
      bus.in_valid = 1'b1;
      bus.in_data  = 33'h1_2345_6789;
      tick();
      bus.in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) tick();
         check_beat("single", x1c[ord(k)], k);
      end
      tick();
      check("single done valid", 32'(bus.out_valid), 32'd0);
      check("single done ready", 32'(bus.in_ready),  32'd1);

      // Back-to-back words: 8 beats with no bubble
      bus.in_valid = 1'b1;
      bus.in_data  = 33'h1_2345_6789;
      for (int b = 0; b < 8; b++) begin
         tick();
         check_beat("b2b", (b < 4) ? x1c[ord(b % 4)] : w2c[ord(b % 4)], b % 4);
         check("b2b in_ready", 32'(bus.in_ready), (b % 4 == 3) ? 32'd1 : 32'd0);
         if (b == 3) bus.in_data = 33'h0_DEAD_BEEF;
         if (b == 4) bus.in_valid = 1'b0;
      end
      tick();
      check("b2b done valid", 32'(bus.out_valid), 32'd0);

      // Backpressure on beat 2 for three cycles
      bus.in_valid = 1'b1;
      bus.in_data  = 33'h1_2345_6789;
      tick();
      bus.in_valid = 1'b0;
      check_beat("stall b0", x1c[ord(0)], 0);
      tick();
      check_beat("stall b1", x1c[ord(1)], 1);
      tick();
      bus.out_ready = 1'b0;
      #1;
      check_beat("stall b2", x1c[ord(2)], 2);
      for (int s = 0; s < 3; s++) begin
         tick();
         check_beat("stall hold", x1c[ord(2)], 2);
         check("stall in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      tick();
      check_beat("stall b3", x1c[ord(3)], 3);
      check("stall last ready", 32'(bus.in_ready), 32'd1);
      tick();
      check("stall done valid", 32'(bus.out_valid), 32'd0);

      // Reset during beat 1 discards the word
      bus.in_valid = 1'b1;
      bus.in_data  = 33'h1_2345_6789;
      tick();
      bus.in_valid = 1'b0;
      tick();
      check_beat("pre-rst b1", x1c[ord(1)], 1);
      rst = 1'b1;
      tick();
      check("midrst out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst in_ready",  32'(bus.in_ready),  32'd1);
      rst          = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 33'h0_0000_01FF;
      tick();
      bus.in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) tick();
         check_beat("postrst", f1c[ord(k)], k);
      end
      tick();
      check("postrst done valid", 32'(bus.out_valid), 32'd0);

      // NUM_OUT == 1 configuration
      bus8.in_valid = 1'b1;
      bus8.in_data  = 8'hA5;
      tick();
      bus8.in_valid = 1'b0;
      check("w8 valid",    32'(bus8.out_valid), 32'd1);
      check("w8 data",     32'(bus8.out_data),  32'hA5);
      check("w8 idx",      32'(bus8.out_idx),   32'd0);
      check("w8 last",     32'(bus8.out_last),  32'd1);
      check("w8 in_ready", 32'(bus8.in_ready),  32'd1);
      tick();
      check("w8 done valid", 32'(bus8.out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
